cpu_control_unit: RTL and testbench
===================================

CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 Parameter: RESET_PC, 4'h0, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: mem_address  output  4  word address to the 16x8 program/data memory.
REQ-005 Port: mem_read  output  1  memory read strobe; read data is combinational and valid in the same cycle.
REQ-006 Port: mem_write  output  1  memory write strobe, one cycle per store.
REQ-007 Port: mem_wdata  output  8  store data; always equals AC.
REQ-008 Port: mem_rdata  input  8  memory read data.
REQ-009 Port: ac  output  8  accumulator.
REQ-010 Port: carry  output  1  carry-out of the last ADD.
REQ-011 Port: pc  output  4  program counter.
REQ-012 Port: halted  output  1  high while in HALT.

Function
REQ-013 Instruction word SHALL decode as [7:5] opcode, [4] indirect bit I, [3:0] address field.
REQ-014 Opcodes SHALL be: 000 AND, 001 ADD, 010 LDA, 011 STA, 100 JMP, 111 HLT; 101 and 110 execute as NOP.
REQ-015 The FSM SHALL have states FETCH, DECODE, INDIRECT, EXECUTE, HALT.
REQ-016 FETCH: mem_address=pc, mem_read=1; IR captures mem_rdata at the edge; pc increments mod 16 (15 -> 0); next state DECODE.
REQ-017 DECODE: EA<=IR[3:0]; next INDIRECT if I=1 (see REQ-030), HALT if opcode 111, FETCH if NOP, else EXECUTE.
REQ-018 INDIRECT: mem_address=EA, mem_read=1; EA<=mem_rdata[3:0] (bits [7:4] ignored); next EXECUTE, or FETCH for NOP.
REQ-019 EXECUTE: AND/ADD/LDA drive mem_address=EA, mem_read=1, and update AC from mem_rdata at the edge; next FETCH.
REQ-020 ADD: {carry,ac} <= ac + mem_rdata, 9-bit sum, ac wraps mod 256; carry unchanged by every other opcode.
REQ-021 STA: mem_address=EA, mem_write=1, mem_wdata=ac for exactly one cycle; mem_read=0 in that cycle.
REQ-022 JMP: pc<=EA in EXECUTE; no memory access in that cycle.
REQ-023 mem_read and mem_write SHALL never be high in the same cycle.
REQ-024 HALT: mem_read=mem_write=0, halted=1, all registers hold; exit only via rst.
REQ-025 Latency: direct AND/ADD/LDA/STA/JMP 3 cycles, +1 if indirect; NOP 2 cycles (3 if indirect); HLT reaches HALT after 2 cycles.
REQ-026 In states without a memory access, mem_address SHALL equal pc and both strobes SHALL be 0.

Reset
REQ-027 While rst=1 at a rising edge: state<=FETCH, pc<=RESET_PC, ac<=0, carry<=0, IR<=0, EA<=0, halted<=0.
REQ-028 mem_write SHALL be forced to 0 combinationally whenever rst=1, including reset asserted during an STA EXECUTE cycle; no partial store occurs.
REQ-029 First fetch SHALL occur in the first cycle after rst deasserts, at address RESET_PC.

Configuration
REQ-030 Macro CTRL_INDIRECT_EN: when defined, I=1 routes DECODE -> INDIRECT per REQ-018; when undefined, bit 4 is ignored, the INDIRECT state is not built, and all instructions use direct addressing.

Verification
REQ-031 Memory {0:0x4A,1:0x2B,2:0x6C,3:0xE0,A:0x05,B:0x03}, release reset -> ac=0x08, one write of 0x08 to addr 0xC, halted=1 exactly 11 cycles after reset release, pc=0x4.
REQ-032 LDA 0xA (M[A]=0xFF) then ADD 0xB (M[B]=0x01) -> ac=0x00, carry=1; a following AND with 0x0F -> ac=0x00, carry stays 1.
REQ-033 With CTRL_INDIRECT_EN: M[0]=0x5A, M[A]=0x0D, M[D]=0x77 -> ac=0x77 after 4 cycles; without the macro -> ac=0x0D after 3 cycles.
REQ-034 M[0]=0x84 (JMP 0x4), M[4..F]=0xA0 (NOP) -> pc sequence 0,1,4,5,...,F,0, wrap with no stall, no write strobes.
REQ-035 Assert rst during the STA EXECUTE cycle -> mem_write=0 that cycle, memory unchanged, next cycle pc=RESET_PC, ac=0, state FETCH.
REQ-036 M[0]=0xE0 -> halted=1 after 2 cycles, held with strobes low for 20 cycles; rst pulse -> refetch from RESET_PC.

Source files
------------

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle accumulator CPU controller (FETCH/DECODE/INDIRECT/EXECUTE/HALT).
// Optional indirect addressing is built only when CTRL_INDIRECT_EN is defined.
module cpu_control_unit #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] mem_address,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [7:0] ac,
    output logic       carry,
    output logic [3:0] pc,
    output logic       halted
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
`ifdef CTRL_INDIRECT_EN
        S_INDIRECT = 3'd2,
`endif
        S_EXECUTE  = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] ea_q, ea_d;
    logic [7:0] ac_q, ac_d;
    logic [7:0] ir_q, ir_d;
    logic       carry_q, carry_d;

    logic [2:0] opcode;
    logic       is_nop;

    assign opcode = ir_q[7:5];
    assign is_nop = (opcode == 3'b101) || (opcode == 3'b110);

`ifndef CTRL_INDIRECT_EN
    // Without indirect support the I bit carries no meaning.
    logic unused_ind;
    assign unused_ind = ir_q[4];
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_HLT) begin
                    state_d = S_HALT;
                end else if (is_nop) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXECUTE;
                end
`ifdef CTRL_INDIRECT_EN
                if (ir_q[4]) begin
                    state_d = S_INDIRECT;
                end
`endif
            end
`ifdef CTRL_INDIRECT_EN
            S_INDIRECT: begin
                if (is_nop) begin
                    state_d = S_FETCH;
                end else if (opcode == OP_HLT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
`endif
            S_EXECUTE: state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    // Architectural registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            ea_q    <= 4'h0;
            ac_q    <= 8'h00;
            ir_q    <= 8'h00;
            carry_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ea_q    <= ea_d;
            ac_q    <= ac_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
        end
    end

    // Register next values; everything holds unless the current state updates it.
    always_comb begin
        pc_d    = pc_q;
        ea_d    = ea_q;
        ac_d    = ac_q;
        ir_d    = ir_q;
        carry_d = carry_q;
        unique case (state_q)
            S_FETCH: begin
                ir_d = mem_rdata;
                pc_d = pc_q + 4'd1;
            end
            S_DECODE: ea_d = ir_q[3:0];
`ifdef CTRL_INDIRECT_EN
            S_INDIRECT: ea_d = mem_rdata[3:0];
`endif
            S_EXECUTE: begin
                case (opcode)
                    OP_AND:  ac_d = ac_q & mem_rdata;
                    OP_ADD:  {carry_d, ac_d} = {1'b0, ac_q} + {1'b0, mem_rdata};
                    OP_LDA:  ac_d = mem_rdata;
                    OP_JMP:  pc_d = ea_q;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Memory strobes; a store is suppressed while rst is high.
    always_comb begin
        mem_address = pc_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        unique case (state_q)
            S_FETCH: mem_read = 1'b1;
`ifdef CTRL_INDIRECT_EN
            S_INDIRECT: begin
                mem_address = ea_q;
                mem_read    = 1'b1;
            end
`endif
            S_EXECUTE: begin
                case (opcode)
                    OP_AND, OP_ADD, OP_LDA: begin
                        mem_address = ea_q;
                        mem_read    = 1'b1;
                    end
                    OP_STA: begin
                        mem_address = ea_q;
                        mem_write   = ~rst;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign mem_wdata = ac_q;
    assign ac        = ac_q;
    assign carry     = carry_q;
    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed program runs against a 16x8 memory model,
// with scoreboard queues for stores and fetch addresses.
module tb_cpu_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] mem_address;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] ac;
    logic       carry;
    logic [3:0] pc;
    logic       halted;

    logic [7:0]  mem [16];
    logic [7:0]  img [16];
    logic        load;
    logic [11:0] wr_log [$];
    logic [11:0] exp_wr [$];
    logic [3:0]  exp_fa [$];
    int          both_cnt = 0;
    int          wr_rd;
    int          tests;
    int          fails;

    cpu_control_unit #(.RESET_PC(4'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .ac          (ac),
        .carry       (carry),
        .pc          (pc),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_address];

    // Memory model: image load, store capture, strobe overlap monitor.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) mem[i] <= img[i];
        end else if (mem_write) begin
            mem[mem_address] <= mem_wdata;
            wr_log.push_back({mem_address, mem_wdata});
        end
        if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_img;
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
    endtask

    task automatic start;
        rst  = 1'b1;
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        rst = 1'b0;
        #1;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_wrcnt"}, 32'(wr_log.size()), 32'(wr_rd + exp_wr.size()));
        while (exp_wr.size() > 0 && wr_rd < wr_log.size()) begin
            chk({tag, "_wr"}, 32'(wr_log[wr_rd]), 32'(exp_wr.pop_front()));
            wr_rd++;
        end
        exp_wr.delete();
        wr_rd = wr_log.size();
    endtask

    initial begin
        logic [3:0] e;
        rst   = 1'b1;
        load  = 1'b0;
        tests = 0;
        fails = 0;
        wr_rd = 0;

        // LDA/ADD/STA/HLT program and reset state
        clear_img();
        img[0]  = 8'h4A;
        img[1]  = 8'h2B;
        img[2]  = 8'h6C;
        img[3]  = 8'hE0;
        img[10] = 8'h05;
        img[11] = 8'h03;
        start();
        chk("rst_pc", 32'(pc), 0);
        chk("rst_ac", 32'(ac), 0);
        chk("rst_carry", 32'(carry), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_read", 32'(mem_read), 1);
        chk("rst_write", 32'(mem_write), 0);
        chk("rst_addr", 32'(mem_address), 0);
        exp_wr.push_back({4'hC, 8'h08});
        step(10);
        chk("p1_halt_early", 32'(halted), 0);
        step(1);
        chk("p1_halt", 32'(halted), 1);
        chk("p1_ac", 32'(ac), 32'h08);
        chk("p1_pc", 32'(pc), 4);
        chk("p1_strobes", 32'({mem_read, mem_write}), 0);
        check_writes("p1");
        chk("p1_memC", 32'(mem[12]), 32'h08);

        // ADD carry out, AND keeps carry
        clear_img();
        img[0]  = 8'h4A;
        img[1]  = 8'h2B;
        img[2]  = 8'h0C;
        img[3]  = 8'hE0;
        img[10] = 8'hFF;
        img[11] = 8'h01;
        img[12] = 8'h0F;
        start();
        step(3);
        chk("p2_lda_ac", 32'(ac), 32'hFF);
        chk("p2_lda_c", 32'(carry), 0);
        step(3);
        chk("p2_add_ac", 32'(ac), 32'h00);
        chk("p2_add_c", 32'(carry), 1);
        step(3);
        chk("p2_and_ac", 32'(ac), 32'h00);
        chk("p2_and_c", 32'(carry), 1);
        step(2);
        chk("p2_halt", 32'(halted), 1);
        check_writes("p2");

        // Indirect bit
        clear_img();
        img[0]  = 8'h5A;
        img[10] = 8'h0D;
        img[13] = 8'h77;
        start();
`ifdef CTRL_INDIRECT_EN
        step(3);
        chk("p3_ind_mid", 32'(ac), 0);
        step(1);
        chk("p3_ind_ac", 32'(ac), 32'h77);
`else
        step(3);
        chk("p3_dir_ac", 32'(ac), 32'h0D);
`endif

        // JMP then NOP sled with pc wrap
        clear_img();
        img[0] = 8'h84;
        for (int a = 4; a < 16; a++) img[a] = 8'hA0;
        start();
        exp_fa.push_back(4'h0);
        for (int a = 4; a < 16; a++) exp_fa.push_back(4'(a));
        exp_fa.push_back(4'h0);
        e = exp_fa.pop_front();
        chk("p4_fa0", 32'(mem_address), 32'(e));
        step(3);
        while (exp_fa.size() > 1) begin
            e = exp_fa.pop_front();
            chk("p4_fa", 32'(mem_address), 32'(e));
            chk("p4_rd", 32'(mem_read), 1);
            step(1);
            chk("p4_pc", 32'(pc), 32'(4'(e + 4'd1)));
            step(1);
        end
        e = exp_fa.pop_front();
        chk("p4_wrap", 32'(mem_address), 32'(e));
        chk("p4_wrap_pc", 32'(pc), 0);
        check_writes("p4");

        // Reset during STA execute
        clear_img();
        img[0]  = 8'h4A;
        img[1]  = 8'h6C;
        img[10] = 8'h55;
        img[12] = 8'h11;
        start();
        step(3);
        chk("p5_ac", 32'(ac), 32'h55);
        step(2);
        chk("p5_sta_wr", 32'(mem_write), 1);
        chk("p5_sta_addr", 32'(mem_address), 32'hC);
        rst = 1'b1;
        #1;
        chk("p5_wr_gated", 32'(mem_write), 0);
        step(1);
        chk("p5_pc", 32'(pc), 0);
        chk("p5_ac0", 32'(ac), 0);
        chk("p5_fetch", 32'({mem_read, mem_address}), 32'h10);
        chk("p5_memC", 32'(mem[12]), 32'h11);
        rst = 1'b0;
        #1;
        step(1);
        chk("p5_decode", 32'(mem_read), 0);
        check_writes("p5");

        // HLT hold and reset exit
        clear_img();
        img[0] = 8'hE0;
        start();
        step(1);
        chk("p6_halt_early", 32'(halted), 0);
        step(1);
        chk("p6_halt", 32'(halted), 1);
        chk("p6_pc", 32'(pc), 1);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("p6_hold", 32'({halted, mem_read, mem_write}), 32'b100);
            chk("p6_hold_pc", 32'(pc), 1);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        chk("p6_refetch", 32'({mem_read, mem_address}), 32'h10);
        chk("p6_pc0", 32'(pc), 0);
        chk("p6_unhalt", 32'(halted), 0);
        step(2);
        chk("p6_rehalt", 32'(halted), 1);
        check_writes("p6");
        chk("rw_overlap", 32'(both_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
